// File: rtl/izh_pkg.sv
// rtl/izh_pkg.sv - shared types and constants for the Izhikevich parameter loader
package izh_pkg;

  // Loader frame FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    COMMIT  = 2'd3
  } izh_state_t;

  // Payload is a_hi, a_lo, b_hi, b_lo, c_hi, c_lo, d_hi, d_lo
  localparam int PAYLOAD_BYTES = 8;
  localparam int IDX_W         = $clog2(PAYLOAD_BYTES);

  // Frame start byte used when the instance does not override it
  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  // Regular-spiking preset in Q8.8, shared with the neuron benches
  localparam logic signed [15:0] RS_A = 16'sd5;
  localparam logic signed [15:0] RS_B = 16'sd51;
  localparam logic signed [15:0] RS_C = -16'sd16640;
  localparam logic signed [15:0] RS_D = 16'sd2048;

endpackage

// File: rtl/izh_frame_timer.sv
// rtl/izh_frame_timer.sv - inter-byte idle timeout counter for the loader
module izh_frame_timer #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // Fires in the cycle whose edge would take the count to TIMEOUT_CYCLES;
  // a clear in the same cycle (byte accepted) suppresses it.
  assign expired = run && !clear && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count idle cycles while a frame is open; restart on any accepted byte
  always_ff @(posedge clk) begin
    if (reset || clear || !run || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/izh_param_loader.sv
// rtl/izh_param_loader.sv - framed byte-stream loader for neuron parameters (IZH_PRESET_EN selects reset preset)
module izh_param_loader
  import izh_pkg::*;
#(
  parameter logic [7:0] HEADER         = DEFAULT_HEADER,
  parameter int         TIMEOUT_CYCLES = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [15:0] param_a,
  output logic signed [15:0] param_b,
  output logic signed [15:0] param_c,
  output logic signed [15:0] param_d,
  output logic               params_ready,
  output logic               busy,
  output logic               load_done,
  output logic               frame_err
);

`ifdef IZH_PRESET_EN
  localparam logic signed [15:0] RST_A     = RS_A;
  localparam logic signed [15:0] RST_B     = RS_B;
  localparam logic signed [15:0] RST_C     = RS_C;
  localparam logic signed [15:0] RST_D     = RS_D;
  localparam logic               RST_READY = 1'b1;
`else
  localparam logic signed [15:0] RST_A     = '0;
  localparam logic signed [15:0] RST_B     = '0;
  localparam logic signed [15:0] RST_C     = '0;
  localparam logic signed [15:0] RST_D     = '0;
  localparam logic               RST_READY = 1'b0;
`endif

  izh_state_t state, next_state;

  logic [IDX_W-1:0]                  idx;
  logic [7:0]                        run_xor;
  logic [PAYLOAD_BYTES-1:0][7:0]     shadow;

  logic accept;
  logic start_frame;
  logic store_byte;
  logic err_set;
  logic commit_en;
  logic timer_run;
  logic expired;

  assign in_ready  = (state != COMMIT);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign timer_run = (state == PAYLOAD) || (state == CHECK);

  izh_frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .run    (timer_run),
    .expired(expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and datapath strobes; an accepted byte always beats a timeout
  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    store_byte  = 1'b0;
    err_set     = 1'b0;
    commit_en   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && (in_data == HEADER)) begin
          next_state  = PAYLOAD;
          start_frame = 1'b1;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          store_byte = 1'b1;
          if (idx == IDX_W'(PAYLOAD_BYTES - 1)) begin
            next_state = CHECK;
          end
        end else if (expired) begin
          err_set    = 1'b1;
          next_state = IDLE;
        end
      end
      CHECK: begin
        if (accept) begin
          if (in_data == run_xor) begin
            next_state = COMMIT;
          end else begin
            err_set    = 1'b1;
            next_state = IDLE;
          end
        end else if (expired) begin
          err_set    = 1'b1;
          next_state = IDLE;
        end
      end
      COMMIT: begin
        commit_en  = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Shadow register, byte index and running checksum; wiped at frame start and on any error
  always_ff @(posedge clk) begin
    if (reset || start_frame || err_set) begin
      idx     <= '0;
      run_xor <= '0;
      shadow  <= '0;
    end else if (store_byte) begin
      shadow[idx] <= in_data;
      run_xor     <= run_xor ^ in_data;
      idx         <= idx + IDX_W'(1);
    end
  end

  // Committed parameters and status pulses; parameters move only on commit or reset
  always_ff @(posedge clk) begin
    if (reset) begin
      param_a      <= RST_A;
      param_b      <= RST_B;
      param_c      <= RST_C;
      param_d      <= RST_D;
      params_ready <= RST_READY;
      load_done    <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      load_done <= commit_en;
      frame_err <= err_set;
      if (commit_en) begin
        param_a      <= {shadow[0], shadow[1]};
        param_b      <= {shadow[2], shadow[3]};
        param_c      <= {shadow[4], shadow[5]};
        param_d      <= {shadow[6], shadow[7]};
        params_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_izh_param_loader.sv
// tb/tb_izh_param_loader.sv - directed self-checking bench for izh_param_loader
module tb_izh_param_loader;

  localparam int T = 1023;

  // Frames: header, a, b, c, d, checksum
  localparam logic [79:0] FRM_A   = 80'hA5_0005_0033_BF00_0800_81;
  localparam logic [79:0] FRM_BAD = 80'hA5_0005_0033_BF00_0800_80;
  localparam logic [79:0] FRM_B   = 80'hA5_0102_FFFE_8000_7FFF_02;
  localparam logic [79:0] FRM_H   = 80'hA5_A5A5_0001_0002_0003_00;

`ifdef IZH_PRESET_EN
  localparam logic [15:0] RST_A   = 16'h0005;
  localparam logic [15:0] RST_B   = 16'h0033;
  localparam logic [15:0] RST_C   = 16'hBF00;
  localparam logic [15:0] RST_D   = 16'h0800;
  localparam logic [15:0] RST_RDY = 16'd1;
`else
  localparam logic [15:0] RST_A   = 16'h0000;
  localparam logic [15:0] RST_B   = 16'h0000;
  localparam logic [15:0] RST_C   = 16'h0000;
  localparam logic [15:0] RST_D   = 16'h0000;
  localparam logic [15:0] RST_RDY = 16'd0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] param_a;
  logic signed [15:0] param_b;
  logic signed [15:0] param_c;
  logic signed [15:0] param_d;
  logic               params_ready;
  logic               busy;
  logic               load_done;
  logic               frame_err;

  int total = 0;
  int bad   = 0;

  int ld_cnt    = 0;
  int fe_cnt    = 0;
  int stall_cnt = 0;
  int acc_cnt   = 0;

  izh_param_loader #(
    .HEADER        (8'hA5),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .param_a     (param_a),
    .param_b     (param_b),
    .param_c     (param_c),
    .param_d     (param_d),
    .params_ready(params_ready),
    .busy        (busy),
    .load_done   (load_done),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  // Mid-cycle event counters
  always @(negedge clk) begin
    if (load_done === 1'b1) ld_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
    if (in_valid === 1'b1 && in_ready === 1'b0) stall_cnt++;
    if (in_valid === 1'b1 && in_ready === 1'b1) acc_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic got;
    got      = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int k = 0; k < 8 && !got; k++) begin
      if (in_ready === 1'b1) got = 1'b1;
      step();
    end
    check("byte_accepted", 16'(got), 16'd1);
  endtask

  task automatic send_bytes(input logic [79:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      send_byte(f[79 - 8*i -: 8]);
    end
  endtask

  task automatic send_frame(input logic [79:0] f);
    send_bytes(f, 0, 9);
  endtask

  initial begin
    int ld0;
    int fe0;
    int st0;
    int ac0;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_load_done", 16'(load_done), 16'd0);
    check("rst_frame_err", 16'(frame_err), 16'd0);
    check("rst_params_ready", 16'(params_ready), RST_RDY);
    check("rst_a", param_a, RST_A);
    check("rst_b", param_b, RST_B);
    check("rst_c", param_c, RST_C);
    check("rst_d", param_d, RST_D);

    // Valid frame, back to back
    ld0 = ld_cnt;
    fe0 = fe_cnt;
    send_frame(FRM_A);
    in_valid = 1'b0;
    check("commit_in_ready", 16'(in_ready), 16'd0);
    check("commit_busy", 16'(busy), 16'd1);
    step();
    check("a_load_done", 16'(load_done), 16'd1);
    check("a_param_a", param_a, 16'h0005);
    check("a_param_b", param_b, 16'h0033);
    check("a_param_c", param_c, 16'hBF00);
    check("a_param_d", param_d, 16'h0800);
    check("a_params_ready", 16'(params_ready), 16'd1);
    check("a_busy", 16'(busy), 16'd0);
    check("a_in_ready", 16'(in_ready), 16'd1);
    step();
    check("a_load_done_drop", 16'(load_done), 16'd0);
    check("a_load_done_count", 16'(ld_cnt - ld0), 16'd1);
    check("a_frame_err_count", 16'(fe_cnt - fe0), 16'd0);

    // Second pattern with extreme values
    send_frame(FRM_B);
    in_valid = 1'b0;
    step();
    check("b_load_done", 16'(load_done), 16'd1);
    check("b_param_a", param_a, 16'h0102);
    check("b_param_b", param_b, 16'hFFFE);
    check("b_param_c", param_c, 16'h8000);
    check("b_param_d", param_d, 16'h7FFF);
    step();

    // Header value inside payload is data
    send_frame(FRM_H);
    in_valid = 1'b0;
    step();
    check("h_load_done", 16'(load_done), 16'd1);
    check("h_param_a", param_a, 16'hA5A5);
    check("h_param_b", param_b, 16'h0001);
    check("h_param_c", param_c, 16'h0002);
    check("h_param_d", param_d, 16'h0003);
    step();

    // Bad checksum
    ld0 = ld_cnt;
    send_frame(FRM_BAD);
    in_valid = 1'b0;
    check("bad_frame_err", 16'(frame_err), 16'd1);
    check("bad_busy", 16'(busy), 16'd0);
    step();
    check("bad_frame_err_drop", 16'(frame_err), 16'd0);
    check("bad_param_a_kept", param_a, 16'hA5A5);
    check("bad_param_d_kept", param_d, 16'h0003);
    check("bad_params_ready", 16'(params_ready), 16'd1);
    step();
    check("bad_no_load", 16'(ld_cnt - ld0), 16'd0);

    // Leading junk ignored
    send_byte(8'h3C);
    send_byte(8'h7E);
    in_valid = 1'b0;
    check("junk_busy", 16'(busy), 16'd0);
    send_frame(FRM_A);
    in_valid = 1'b0;
    step();
    check("junk_load_done", 16'(load_done), 16'd1);
    check("junk_param_a", param_a, 16'h0005);
    check("junk_param_c", param_c, 16'hBF00);
    step();

    // Timeout after header plus 3 payload bytes
    send_bytes(FRM_B, 0, 3);
    in_valid = 1'b0;
    repeat (T - 1) step();
    check("to_not_yet_err", 16'(frame_err), 16'd0);
    check("to_not_yet_busy", 16'(busy), 16'd1);
    step();
    check("to_frame_err", 16'(frame_err), 16'd1);
    check("to_busy", 16'(busy), 16'd0);
    step();
    check("to_frame_err_drop", 16'(frame_err), 16'd0);
    check("to_param_a_kept", param_a, 16'h0005);
    send_frame(FRM_B);
    in_valid = 1'b0;
    step();
    check("to_next_load_done", 16'(load_done), 16'd1);
    check("to_next_param_a", param_a, 16'h0102);
    step();

    // Byte arriving on the timeout cycle wins
    send_byte(8'hA5);
    in_valid = 1'b0;
    repeat (T - 1) step();
    check("race_busy_before", 16'(busy), 16'd1);
    send_bytes(FRM_A, 1, 1);
    check("race_busy_after", 16'(busy), 16'd1);
    check("race_no_err", 16'(frame_err), 16'd0);
    send_bytes(FRM_A, 2, 9);
    in_valid = 1'b0;
    step();
    check("race_load_done", 16'(load_done), 16'd1);
    check("race_param_d", param_d, 16'h0800);
    step();

    // Reset mid-frame after 5th payload byte
    ld0 = ld_cnt;
    send_bytes(FRM_B, 0, 5);
    in_valid = 1'b0;
    reset    = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_busy", 16'(busy), 16'd0);
    check("mrst_in_ready", 16'(in_ready), 16'd1);
    check("mrst_params_ready", 16'(params_ready), RST_RDY);
    check("mrst_a", param_a, RST_A);
    check("mrst_d", param_d, RST_D);
    send_bytes(FRM_B, 6, 9);
    in_valid = 1'b0;
    step();
    step();
    check("mrst_no_load", 16'(ld_cnt - ld0), 16'd0);
    check("mrst_busy_after", 16'(busy), 16'd0);
    check("mrst_b_kept", param_b, RST_B);

    // Continuous valid through two frames
    ld0 = ld_cnt;
    st0 = stall_cnt;
    ac0 = acc_cnt;
    fe0 = fe_cnt;
    send_frame(FRM_B);
    send_frame(FRM_A);
    step();
    in_valid = 1'b0;
    check("cont_load_done", 16'(load_done), 16'd1);
    check("cont_param_a", param_a, 16'h0005);
    check("cont_param_b", param_b, 16'h0033);
    check("cont_param_c", param_c, 16'hBF00);
    check("cont_param_d", param_d, 16'h0800);
    check("cont_params_ready", 16'(params_ready), 16'd1);
    step();
    check("cont_loads", 16'(ld_cnt - ld0), 16'd2);
    check("cont_stalls", 16'(stall_cnt - st0), 16'd2);
    check("cont_accepts", 16'(acc_cnt - ac0), 16'd20);
    check("cont_no_err", 16'(fe_cnt - fe0), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/izh_param_loader.md
# izh_param_loader

Byte-serial configuration front end for the Izhikevich neuron core. It receives framed parameter writes over an 8-bit valid/ready stream from the chip I/O pins. Each frame is checked with an XOR checksum, and on success all four parameters are committed to the core atomically. It drives the core's `param_a`/`param_b`/`param_c`/`param_d` and `params_ready` inputs, making it the writer side of the neuron's parameter interface.

## Interface
Parameters:
- `HEADER`, default 8'hA5: frame start byte.
- `TIMEOUT_CYCLES`, default 1023: maximum idle cycles between bytes inside a frame.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `in_data` in 8: byte from the host.
- `in_valid` in 1: `in_data` is valid this cycle.
- `in_ready` out 1: loader accepts a byte this cycle. A byte is accepted when `in_valid & in_ready`.
- `param_a`, `param_b`, `param_c`, `param_d` out 16, signed, Q8.8: committed parameters.
- `params_ready` out 1: committed parameters are valid.
- `busy` out 1: a frame is in progress (state is not IDLE).
- `load_done` out 1: one-cycle pulse on commit.
- `frame_err` out 1: one-cycle pulse on checksum mismatch or timeout.

## Operation
- Frame format: `HEADER`, then 8 payload bytes in the order a_hi, a_lo, b_hi, b_lo, c_hi, c_lo, d_hi, d_lo, then one checksum byte.
- Checksum = XOR of the 8 payload bytes. The header is excluded.
- FSM states and transitions:
  - IDLE: an accepted byte equal to `HEADER` moves to PAYLOAD with idx=0 and running XOR=0. Any other byte is accepted and dropped.
  - PAYLOAD: each accepted byte is written into shadow register byte[idx] and XORed into the running checksum; idx increments. Accepting idx=7 moves to CHECK. A `HEADER` value here is treated as ordinary data.
  - CHECK: the accepted byte is compared with the running XOR. On match, go to COMMIT. On mismatch, pulse `frame_err`, discard the shadow register, and return to IDLE.
  - COMMIT: the shadow register is copied to all four `param_*` outputs on the same edge. `params_ready` is set to 1, `load_done` pulses, and the FSM returns to IDLE.
- `in_ready` is 1 in every state except COMMIT.
- Timeout: a counter clears on each accepted byte and increments every cycle while in PAYLOAD or CHECK. When it reaches `TIMEOUT_CYCLES`: pulse `frame_err`, go to IDLE, and discard the shadow register.
- If a byte is accepted in the same cycle the timeout would fire, the byte wins and the counter clears.
- Outputs change only at COMMIT or reset. A failed or aborted frame leaves the previous parameters and `params_ready` untouched.
- Reset, including mid-frame: state=IDLE, idx=0, shadow register and counter cleared. `busy`=0, `load_done`=0, `frame_err`=0, `in_ready`=1. Parameter outputs and `params_ready` take the values given under Configuration.

## Timing
- Checksum byte accepted at edge N:
  - On match: COMMIT during cycle N..N+1. Parameters, `params_ready` and `load_done` become visible after edge N+1. `load_done` is high for exactly one cycle.
  - On mismatch: `frame_err` is high for the one cycle after edge N.
- Minimum frame length is 11 cycles, back to back. The next header can be accepted on the cycle after COMMIT.
- A timeout fires `TIMEOUT_CYCLES` cycles after the last accepted byte.
- `busy` is registered state: high from the edge that accepts the header until the FSM returns to IDLE.

## Configuration
- `IZH_PRESET_EN` defined: reset loads the regular-spiking preset, a=16'sd5, b=16'sd51, c=-16'sd16640, d=16'sd2048, with `params_ready`=1.
- `IZH_PRESET_EN` undefined: reset clears all parameters to 0 and sets `params_ready`=0 until the first successful commit.
- Frame protocol is identical in both builds.

## Structure
- Package `izh_pkg` holds:
  - the FSM state enum (IDLE, PAYLOAD, CHECK, COMMIT);
  - `PAYLOAD_BYTES`=8;
  - the default header constant;
  - preset constants `RS_A`, `RS_B`, `RS_C`, `RS_D`, shared with the neuron testbenches.
- Sub-module `izh_frame_timer` holds the timeout counter, with ports `clear`, `run`, and a one-cycle `expired` pulse. Counter width is $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Valid frame A5 00 05 00 33 BF 00 08 00 81, sent back to back → one `load_done` pulse; a=5, b=51, c=-16640, d=2048; `params_ready`=1; no `frame_err`.
- Same frame with checksum 0x80 → `frame_err` pulse one cycle after the checksum byte; parameters and `params_ready` unchanged.
- Bytes 3C 7E before A5, followed by a valid frame → leading bytes ignored; frame commits normally.
- Send header plus 3 payload bytes, then idle `TIMEOUT_CYCLES` cycles → `frame_err` pulse, FSM back in IDLE; a following full frame commits.
- Assert reset after the 5th payload byte → `busy`=0, outputs at preset or zero per `IZH_PRESET_EN`; the remaining bytes do not commit.
- Hold `in_valid` high continuously through two frames → `in_ready`=0 exactly one cycle at each COMMIT; no bytes lost; the second frame's values are committed.
